// File: rtl/cpu_pkg.sv
// Types and widths shared by the multicycle CPU control FSM and its memory access stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    FAIL
  } mau_state_t;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

endpackage

// File: rtl/mau_timer.sv
// Wait-cycle counter for the memory access unit: cleared at launch, counts while a
// request is outstanding, saturates at TIMEOUT.
module mau_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] SAT  = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && count != SAT) begin
      count <= count + 1'b1;
    end
  end

  // High during the last wait cycle still allowed to see an ack.
  assign expired = (count >= LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle CPU: turns control strobes into one req/ack bus
// transaction, owns IR and MDR, and reports busy/done/err back to the control FSM.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              iord,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  mau_state_t state, nextState;

  logic              armed;
  logic              launch;
  logic              launchBad;
  logic              timerExpired;
  logic [ADDR_W-1:0] launchAddr;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              reqWe;
  logic              reqIord;
  logic              reqIrWrite;

  assign launchAddr = iord ? alu_out : pc;
  assign launch     = (state == IDLE) && armed && (mem_read || mem_write);
  assign launchBad  = (mem_read && mem_write) || (launchAddr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Bus outputs are forced to zero outside WAIT so reset and idle look identical.
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      IDLE: begin
        busy = launch;
        if (launch) begin
          nextState = launchBad ? FAIL : WAIT;
        end
      end
      WAIT: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        bus_we    = reqWe;
        bus_addr  = reqAddr;
        bus_wdata = reqWdata;
        if (bus_ack) begin
          nextState = DONE;
        end else if (timerExpired) begin
          nextState = FAIL;
        end
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      FAIL: begin
        err       = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // A strobe held past completion must be released before another access can start.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b1;
    end else if (!mem_read && !mem_write) begin
      armed <= 1'b1;
    end else if (nextState inside {DONE, FAIL}) begin
      armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (launch) begin
      reqAddr    <= launchAddr;
      reqWdata   <= wdata;
      reqWe      <= mem_write;
      reqIord    <= iord;
      reqIrWrite <= ir_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir  <= '0;
      mdr <= '0;
    end else if (state == WAIT && bus_ack && !reqWe) begin
      mdr <= bus_rdata;
      if (reqIrWrite && !reqIord) begin
        ir <= bus_rdata;
      end
    end
  end

  mau_timer #(
    .TIMEOUT(TIMEOUT)
  ) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (launch),
    .en     (state == WAIT),
    .expired(timerExpired)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (long and short timeout) driven by directed
// and randomized accesses, checked against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO_A = 16;
  localparam int TMO_T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] pc, alu_out;
  logic [DW-1:0] wdata, bus_rdata;
  logic          iord, ir_write, bus_ack;
  logic          rdA, wrA, rdT, wrT;

  logic [DW-1:0] irA, mdrA, bwdA, irT, mdrT, bwdT;
  logic [AW-1:0] baA, baT;
  logic          busyA, doneA, errA, reqA, weA;
  logic          busyT, doneT, errT, reqT, weT;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO_A)) dutA (
    .clk(clk), .rst(rst), .mem_read(rdA), .mem_write(wrA), .iord(iord), .ir_write(ir_write),
    .pc(pc), .alu_out(alu_out), .wdata(wdata), .ir(irA), .mdr(mdrA), .busy(busyA),
    .done(doneA), .err(errA), .bus_req(reqA), .bus_we(weA), .bus_addr(baA),
    .bus_wdata(bwdA), .bus_ack(bus_ack), .bus_rdata(bus_rdata));

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO_T)) dutT (
    .clk(clk), .rst(rst), .mem_read(rdT), .mem_write(wrT), .iord(iord), .ir_write(ir_write),
    .pc(pc), .alu_out(alu_out), .wdata(wdata), .ir(irT), .mdr(mdrT), .busy(busyT),
    .done(doneT), .err(errT), .bus_req(reqT), .bus_we(weT), .bus_addr(baT),
    .bus_wdata(bwdT), .bus_ack(bus_ack), .bus_rdata(bus_rdata));

  bit            useT;
  logic          oBusy, oDone, oErr, oReq, oWe;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oWdata, oIr, oMdr;

  assign oBusy  = useT ? busyT : busyA;
  assign oDone  = useT ? doneT : doneA;
  assign oErr   = useT ? errT  : errA;
  assign oReq   = useT ? reqT  : reqA;
  assign oWe    = useT ? weT   : weA;
  assign oAddr  = useT ? baT   : baA;
  assign oWdata = useT ? bwdT  : bwdA;
  assign oIr    = useT ? irT   : irA;
  assign oMdr   = useT ? mdrT  : mdrA;

  int            nCmp = 0;
  int            nErr = 0;
  logic [DW-1:0] expIr[2];
  logic [DW-1:0] expMdr[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access as the control FSM would issue it: strobe held until done/err.
  task automatic do_access(input bit sel, input bit rd, input bit wr, input bit io,
                           input bit irw, input logic [AW-1:0] pcv, input logic [AW-1:0] alu,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rdata,
                           input int ackDelay, input string name);
    int            tmo   = sel ? TMO_T : TMO_A;
    logic [AW-1:0] addr  = io ? alu : pcv;
    bit            bad   = (rd && wr) || (addr[1:0] != 2'b00);
    bit            acked = 1'b0;
    int            idx   = sel ? 1 : 0;
    useT      = sel;
    pc        = pcv;
    alu_out   = alu;
    wdata     = wd;
    iord      = io;
    ir_write  = irw;
    bus_rdata = rdata;
    if (sel) begin rdT = rd; wrT = wr; end
    else     begin rdA = rd; wrA = wr; end
    #1;
    nCmp++;
    if (oBusy !== 1'b1) begin
      nErr++; $display("FAIL %s launch busy: got %b want 1", name, oBusy);
    end
    tick();
    if (!bad) begin
      for (int k = 0; k < tmo && !acked; k++) begin
        nCmp++;
        if ({oReq, oWe, oAddr, oDone, oErr} !== {1'b1, wr, addr, 1'b0, 1'b0}) begin
          nErr++;
          $display("FAIL %s wait[%0d]: got req=%b we=%b addr=%h done=%b err=%b want req=1 we=%b addr=%h done=0 err=0",
                   name, k, oReq, oWe, oAddr, oDone, oErr, wr, addr);
        end
        if (wr) begin
          nCmp++;
          if (oWdata !== wd) begin
            nErr++; $display("FAIL %s wdata[%0d]: got %h want %h", name, k, oWdata, wd);
          end
        end
        if (k == ackDelay) begin
          bus_ack = 1'b1;
          acked   = 1'b1;
        end
        tick();
        bus_ack = 1'b0;
      end
    end
    if (acked && !wr) begin
      expMdr[idx] = rdata;
      if (irw && !io) expIr[idx] = rdata;
    end
    nCmp++;
    if ({oDone, oErr, oReq} !== {acked, !acked, 1'b0}) begin
      nErr++;
      $display("FAIL %s end: got done=%b err=%b req=%b want done=%b err=%b req=0",
               name, oDone, oErr, oReq, acked, !acked);
    end
    nCmp++;
    if ({oIr, oMdr} !== {expIr[idx], expMdr[idx]}) begin
      nErr++;
      $display("FAIL %s regs: got ir=%h mdr=%h want ir=%h mdr=%h",
               name, oIr, oMdr, expIr[idx], expMdr[idx]);
    end
    rdA = 0; wrA = 0; rdT = 0; wrT = 0;
    tick();
    nCmp++;
    if ({oBusy, oDone, oErr, oReq} !== 4'b0000) begin
      nErr++;
      $display("FAIL %s idle: got busy=%b done=%b err=%b req=%b want all 0",
               name, oBusy, oDone, oErr, oReq);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    nCmp++;
    if ({irA, mdrA, busyA, doneA, errA, reqA, weA, baA, bwdA} !== '0) begin
      nErr++; $display("FAIL reset A: got ir=%h mdr=%h req=%b addr=%h want all 0", irA, mdrA, reqA, baA);
    end
    nCmp++;
    if ({irT, mdrT, busyT, doneT, errT, reqT, weT, baT, bwdT} !== '0) begin
      nErr++; $display("FAIL reset T: got ir=%h mdr=%h req=%b addr=%h want all 0", irT, mdrT, reqT, baT);
    end
    rst = 1'b0;
    expIr  = '{default: '0};
    expMdr = '{default: '0};
    tick();
  endtask

  task automatic test_fetch();
    do_access(0, 1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h00500093, 2, "fetch");
    nCmp++;
    if ({irA, mdrA} !== {32'h00500093, 32'h00500093}) begin
      nErr++; $display("FAIL fetch ir/mdr: got %h/%h want 00500093/00500093", irA, mdrA);
    end
  endtask

  task automatic test_load();
    do_access(0, 1, 0, 1, 0, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 0, "load");
    nCmp++;
    if ({irA, mdrA} !== {32'h00500093, 32'hDEADBEEF}) begin
      nErr++; $display("FAIL load ir/mdr: got %h/%h want 00500093/deadbeef", irA, mdrA);
    end
  endtask

  task automatic test_store();
    do_access(0, 0, 1, 1, 0, 32'h48, 32'h204, 32'h1234, 32'h5555AAAA, 5, "store");
    nCmp++;
    if (mdrA !== 32'hDEADBEEF) begin
      nErr++; $display("FAIL store mdr: got %h want deadbeef", mdrA);
    end
  endtask

  task automatic test_errors();
    do_access(0, 1, 0, 1, 0, 32'h48, 32'h102, 32'h0, 32'h11111111, 0, "misaligned");
    do_access(0, 1, 1, 0, 0, 32'h40, 32'h200, 32'h9, 32'h22222222, 0, "both_strobes");
    // Ack with no request outstanding must be ignored.
    bus_rdata = 32'h33333333;
    bus_ack   = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    nCmp++;
    if ({mdrA, doneA, errA} !== {expMdr[0], 1'b0, 1'b0}) begin
      nErr++; $display("FAIL stray_ack: got mdr=%h done=%b err=%b want mdr=%h done=0 err=0",
                       mdrA, doneA, errA, expMdr[0]);
    end
  endtask

  task automatic test_timeout();
    do_access(1, 1, 0, 0, 1, 32'h80, 32'h0, 32'h0, 32'hCAFEF00D, 1, "t_fetch");
    do_access(1, 1, 0, 1, 0, 32'h80, 32'h300, 32'h0, 32'h44444444, 99, "timeout_t");
    nCmp++;
    if ({irT, mdrT} !== {32'hCAFEF00D, 32'hCAFEF00D}) begin
      nErr++; $display("FAIL timeout kept: got %h/%h want cafef00d/cafef00d", irT, mdrT);
    end
    do_access(0, 0, 1, 1, 0, 32'h80, 32'h400, 32'h77, 32'h0, 99, "timeout_a");
  endtask

  task automatic test_hold();
    int launches = 0;
    int dones    = 0;
    bit prev     = 1'b0;
    useT      = 1'b0;
    iord      = 1'b1;
    ir_write  = 1'b0;
    alu_out   = 32'h300;
    bus_rdata = 32'h13579BDF;
    rdA       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (reqA && !prev) launches++;
      prev = reqA;
      if (doneA) dones++;
      bus_ack = reqA;
    end
    rdA     = 1'b0;
    bus_ack = 1'b0;
    tick();
    expMdr[0] = 32'h13579BDF;
    nCmp++;
    if (launches != 1 || dones != 1) begin
      nErr++; $display("FAIL hold: got launches=%0d dones=%0d want 1/1", launches, dones);
    end
    nCmp++;
    if (mdrA !== 32'h13579BDF) begin
      nErr++; $display("FAIL hold mdr: got %h want 13579bdf", mdrA);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int            r   = $urandom_range(0, 9);
      bit            rd  = (r < 6) || (r == 9);
      bit            wr  = (r >= 6);
      logic [AW-1:0] a   = $urandom() & 32'hFFFF_FFFC;
      logic [AW-1:0] p   = $urandom() & 32'hFFFF_FFFC;
      int            dly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      do_access(0, rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p, a,
                $urandom(), $urandom(), dly, "random");
    end
  endtask

  task automatic test_reset_mid_wait();
    useT     = 1'b0;
    iord     = 1'b0;
    ir_write = 1'b1;
    pc       = 32'h88;
    wdata    = 32'hABCD;
    rdA      = 1'b1;
    tick();
    nCmp++;
    if (reqA !== 1'b1) begin
      nErr++; $display("FAIL rst_mid req: got %b want 1", reqA);
    end
    rst = 1'b1;
    rdA = 1'b0;
    tick();
    nCmp++;
    if ({irA, mdrA, busyA, doneA, errA, reqA, weA, baA, bwdA} !== '0) begin
      nErr++; $display("FAIL rst_mid outputs: got ir=%h mdr=%h req=%b addr=%h want all 0", irA, mdrA, reqA, baA);
    end
    rst = 1'b0;
    expIr  = '{default: '0};
    expMdr = '{default: '0};
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    nCmp++;
    if ({doneA, errA, reqA, mdrA} !== '0) begin
      nErr++; $display("FAIL rst_mid after: got done=%b err=%b req=%b mdr=%h want 0", doneA, errA, reqA, mdrA);
    end
  endtask

  initial begin
    rst = 1'b1; pc = '0; alu_out = '0; wdata = '0; bus_rdata = '0;
    iord = 0; ir_write = 0; bus_ack = 0;
    rdA = 0; wrA = 0; rdT = 0; wrT = 0;
    useT = 1'b0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_hold();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
